// File: rtl/atm_controller.sv
// ATM session controller: card/PIN/menu FSM with a registered balance,
// PIN-retry lockout and an inactivity timeout that returns the card.
module atm_controller #(
    parameter int               BAL_W     = 16,
    parameter logic [BAL_W-1:0] INIT_BAL  = 16'd500,
    parameter int               MAX_TRIES = 3,
    parameter int               TIMEOUT   = 1000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             card_i,
    input  logic             enter_i,
    input  logic             cancel_i,
    input  logic             pin_ok_i,
    input  logic [1:0]       option_i,
    input  logic [BAL_W-1:0] amount_i,
    output logic [2:0]       state_o,
    output logic [BAL_W-1:0] balance_o,
    output logic             dispense_o,
    output logic             eject_o,
    output logic             err_o,
    output logic             locked_o
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_PIN   = 3'b001;
    localparam logic [2:0] S_MENU  = 3'b010;
    localparam logic [2:0] S_BAL   = 3'b011;
    localparam logic [2:0] S_WDR   = 3'b100;
    localparam logic [2:0] S_DEP   = 3'b101;
    localparam logic [2:0] S_EJECT = 3'b110;
    localparam logic [2:0] S_LOCK  = 3'b111;

    logic [2:0]       state_q, state_d;
    logic [BAL_W-1:0] balance_q, balance_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dispense_q, dispense_d;
    logic             err_q, err_d;
    logic             eject_q, eject_d;
    logic             locked_q, locked_d;
    logic [BAL_W:0]   dep_sum;
    logic             active;

    always_comb begin
        state_d    = state_q;
        balance_d  = balance_q;
        tries_d    = tries_q;
        dispense_d = 1'b0;
        err_d      = 1'b0;
        dep_sum    = {1'b0, balance_q} + {1'b0, amount_i};
        active     = (state_q >= S_PIN) && (state_q <= S_DEP);

        case (state_q)
            S_IDLE: begin
                if (card_i) begin
                    state_d = S_PIN;
                    tries_d = '0;
                end
            end
            S_EJECT: state_d = S_IDLE;
            S_LOCK:  state_d = S_LOCK;
            default: begin
                // cancel beats enter, and enter beats the inactivity timeout
                if (cancel_i) begin
                    state_d = S_EJECT;
                end else if (enter_i) begin
                    case (state_q)
                        S_PIN: begin
                            if (pin_ok_i) begin
                                state_d = S_MENU;
                                tries_d = '0;
                            end else begin
                                err_d   = 1'b1;
                                tries_d = tries_q + TRY_W'(1);
                                if (tries_d == TRY_W'(MAX_TRIES)) state_d = S_LOCK;
                            end
                        end
                        S_MENU: begin
                            case (option_i)
                                2'b00:   state_d = S_BAL;
                                2'b01:   state_d = S_WDR;
                                2'b10:   state_d = S_DEP;
                                default: state_d = S_EJECT;
                            endcase
                        end
                        S_WDR: begin
                            state_d = S_MENU;
                            if ((amount_i != '0) && (amount_i <= balance_q)) begin
                                balance_d  = balance_q - amount_i;
                                dispense_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        S_DEP: begin
                            state_d = S_MENU;
                            if ((amount_i != '0) && !dep_sum[BAL_W]) begin
                                balance_d = dep_sum[BAL_W-1:0];
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: state_d = S_MENU;
                    endcase
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    state_d = S_EJECT;
                end
            end
        endcase

        timer_d  = (active && !enter_i && (state_d == state_q)) ? timer_q + TMR_W'(1) : '0;
        eject_d  = (state_d == S_EJECT);
        locked_d = (state_d == S_LOCK);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            balance_q  <= INIT_BAL;
            tries_q    <= '0;
            timer_q    <= '0;
            dispense_q <= 1'b0;
            err_q      <= 1'b0;
            eject_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            balance_q  <= balance_d;
            tries_q    <= tries_d;
            timer_q    <= timer_d;
            dispense_q <= dispense_d;
            err_q      <= err_d;
            eject_q    <= eject_d;
            locked_q   <= locked_d;
        end
    end

    assign state_o    = state_q;
    assign balance_o  = balance_q;
    assign dispense_o = dispense_q;
    assign eject_o    = eject_q;
    assign err_o      = err_q;
    assign locked_o   = locked_q;
endmodule

// File: tb/tb_atm_controller.sv
// Bench for atm_controller: directed scenarios plus randomized sessions,
// every cycle compared against a behavioural account/session model.
module tb_atm_controller;
    localparam int BAL_W     = 16;
    localparam int INIT_BAL  = 500;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 50;
    localparam int BAL_MAX   = (1 << BAL_W) - 1;

    // model state numbering follows the published state encoding
    localparam int IDLE = 0, PIN = 1, MENU = 2, BAL = 3, WDR = 4, DEP = 5, EJECT = 6, LOCK = 7;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             card_i = 1'b0, enter_i = 1'b0, cancel_i = 1'b0, pin_ok_i = 1'b0;
    logic [1:0]       option_i = 2'b00;
    logic [BAL_W-1:0] amount_i = '0;
    logic [2:0]       state_o;
    logic [BAL_W-1:0] balance_o;
    logic             dispense_o, eject_o, err_o, locked_o;

    int n_chk = 0;
    int n_err = 0;

    int m_state, m_bal, m_tries, m_wait;
    bit m_disp, m_err;

    always #5 clk_i = ~clk_i;

    atm_controller #(
        .BAL_W(BAL_W), .INIT_BAL(16'd500), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .card_i(card_i), .enter_i(enter_i),
        .cancel_i(cancel_i), .pin_ok_i(pin_ok_i), .option_i(option_i), .amount_i(amount_i),
        .state_o(state_o), .balance_o(balance_o), .dispense_o(dispense_o),
        .eject_o(eject_o), .err_o(err_o), .locked_o(locked_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_bal = INIT_BAL; m_tries = 0; m_wait = 0;
        m_disp = 0; m_err = 0;
    endtask

    // one clock of the session rules, in plain arithmetic
    task automatic model_step(input bit c, input bit e, input bit x, input bit p,
                              input int o, input int a);
        int nxt;
        bit busy;
        nxt = m_state;
        busy = (m_state >= PIN) && (m_state <= DEP);
        m_disp = 0; m_err = 0;
        if (m_state == IDLE) begin
            if (c) begin nxt = PIN; m_tries = 0; end
        end else if (m_state == EJECT) begin
            nxt = IDLE;
        end else if (busy) begin
            if (x) nxt = EJECT;
            else if (e) begin
                if (m_state == PIN) begin
                    if (p) begin nxt = MENU; m_tries = 0; end
                    else begin
                        m_err = 1; m_tries++;
                        if (m_tries == MAX_TRIES) nxt = LOCK;
                    end
                end else if (m_state == MENU) begin
                    nxt = (o == 0) ? BAL : (o == 1) ? WDR : (o == 2) ? DEP : EJECT;
                end else if (m_state == BAL) begin
                    nxt = MENU;
                end else if (m_state == WDR) begin
                    nxt = MENU;
                    if (a != 0 && a <= m_bal) begin m_bal -= a; m_disp = 1; end
                    else m_err = 1;
                end else begin
                    nxt = MENU;
                    if (a != 0 && m_bal + a <= BAL_MAX) m_bal += a;
                    else m_err = 1;
                end
            end else if (m_wait == TIMEOUT - 1) nxt = EJECT;
        end
        // idle-cycle count: how long the customer has been silent in this screen
        m_wait = (busy && !e && nxt == m_state) ? m_wait + 1 : 0;
        m_state = nxt;
    endtask

    task automatic compare_all(input string ph);
        check_eq({ph, ".state"},    state_o,    m_state);
        check_eq({ph, ".balance"},  balance_o,  m_bal);
        check_eq({ph, ".dispense"}, dispense_o, m_disp);
        check_eq({ph, ".err"},      err_o,      m_err);
        check_eq({ph, ".eject"},    eject_o,    m_state == EJECT);
        check_eq({ph, ".locked"},   locked_o,   m_state == LOCK);
    endtask

    task automatic cycle(input string ph, input bit c, input bit e, input bit x,
                         input bit p, input int o, input int a);
        card_i = c; enter_i = e; cancel_i = x; pin_ok_i = p;
        option_i = o[1:0]; amount_i = a[BAL_W-1:0];
        @(posedge clk_i);
        model_step(c, e, x, p, o, a & BAL_MAX);
        #1;
        compare_all(ph);
    endtask

    task automatic idle(input string ph);
        cycle(ph, 0, 0, 0, 0, 0, 0);
    endtask

    // asserted between edges so the asynchronous clear is visible immediately
    task automatic apply_reset(input string ph);
        card_i = 0; enter_i = 0; cancel_i = 0; pin_ok_i = 0; option_i = 0; amount_i = '0;
        #2 reset_i = 1'b1;
        #1;
        check_eq({ph, ".rst_state"},   state_o,   IDLE);
        check_eq({ph, ".rst_balance"}, balance_o, INIT_BAL);
        check_eq({ph, ".rst_pulses"},  {dispense_o, eject_o, err_o, locked_o}, 0);
        @(posedge clk_i);
        #3 reset_i = 1'b0;
        model_reset();
    endtask

    task automatic login(input string ph);
        cycle(ph, 1, 0, 0, 0, 0, 0);
        cycle(ph, 0, 1, 0, 1, 0, 0);
    endtask

    initial begin
        int lock_cycles;
        int r, amt;
        model_reset();
        #12 reset_i = 1'b0;
        check_eq("init.state", state_o, IDLE);
        check_eq("init.balance", balance_o, INIT_BAL);

        // withdrawal of 200 from 500
        apply_reset("wdr200");
        login("wdr200");
        cycle("wdr200", 0, 1, 0, 0, 1, 0);
        cycle("wdr200", 0, 1, 0, 0, 0, 200);
        check_eq("wdr200.dispense_k", dispense_o, 1);
        check_eq("wdr200.balance_k", balance_o, 300);
        check_eq("wdr200.state_k", state_o, MENU);
        idle("wdr200");
        check_eq("wdr200.pulse_len", dispense_o, 0);
        $display("txn wdr200: balance=%0d state=%0d", balance_o, state_o);

        // over-limit and zero withdrawals
        apply_reset("wdrbad");
        login("wdrbad");
        cycle("wdrbad", 0, 1, 0, 0, 1, 0);
        cycle("wdrbad", 0, 1, 0, 0, 0, 600);
        check_eq("wdr600.err_k", err_o, 1);
        check_eq("wdr600.balance_k", balance_o, 500);
        cycle("wdrbad", 0, 1, 0, 0, 1, 0);
        cycle("wdrbad", 0, 1, 0, 0, 0, 0);
        check_eq("wdr0.err_k", err_o, 1);
        check_eq("wdr0.state_k", state_o, MENU);
        $display("txn wdrbad: balance=%0d", balance_o);

        // three wrong PINs lock the card in
        apply_reset("lock");
        cycle("lock", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("lock", 0, 1, 0, 0, 0, 0);
            check_eq("lock.err_k", err_o, 1);
        end
        check_eq("lock.state_k", state_o, LOCK);
        check_eq("lock.locked_k", locked_o, 1);
        cycle("lock", 1, 1, 1, 1, 3, 0);
        cycle("lock", 1, 0, 1, 0, 0, 0);
        check_eq("lock.hold_k", state_o, LOCK);
        check_eq("lock.no_eject_k", eject_o, 0);
        apply_reset("unlock");
        $display("txn lock: released by reset");

        // deposit up to and past the 16-bit ceiling
        apply_reset("dep");
        login("dep");
        cycle("dep", 0, 1, 0, 0, 2, 0);
        cycle("dep", 0, 1, 0, 0, 0, 64500);
        check_eq("dep.bal65000_k", balance_o, 65000);
        cycle("dep", 0, 1, 0, 0, 2, 0);
        cycle("dep", 0, 1, 0, 0, 0, 600);
        check_eq("dep600.err_k", err_o, 1);
        check_eq("dep600.balance_k", balance_o, 65000);
        cycle("dep", 0, 1, 0, 0, 2, 0);
        cycle("dep", 0, 1, 0, 0, 0, 500);
        check_eq("dep500.balance_k", balance_o, 65500);
        check_eq("dep500.err_k", err_o, 0);
        $display("txn dep: balance=%0d", balance_o);

        // menu inactivity timeout, then enter on the last allowed cycle
        apply_reset("tmo");
        login("tmo");
        for (int i = 0; i < TIMEOUT - 1; i++) idle("tmo");
        check_eq("tmo.still_menu_k", state_o, MENU);
        idle("tmo");
        check_eq("tmo.eject_k", eject_o, 1);
        idle("tmo");
        check_eq("tmo.idle_k", state_o, IDLE);
        login("tmo2");
        for (int i = 0; i < TIMEOUT - 1; i++) idle("tmo2");
        cycle("tmo2", 0, 1, 0, 0, 0, 0);
        check_eq("tmo2.bal_k", state_o, BAL);
        check_eq("tmo2.no_eject_k", eject_o, 0);
        $display("txn timeout: done");

        // cancel beats enter in withdrawal
        apply_reset("cxl");
        login("cxl");
        cycle("cxl", 0, 1, 0, 0, 1, 0);
        cycle("cxl", 0, 1, 1, 0, 0, 100);
        check_eq("cxl.state_k", state_o, EJECT);
        check_eq("cxl.balance_k", balance_o, 500);
        check_eq("cxl.dispense_k", dispense_o, 0);
        $display("txn cancel: state=%0d", state_o);

        // randomized sessions
        lock_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0 || lock_cycles > 12) begin
                apply_reset("rnd");
                lock_cycles = 0;
            end
            r = $urandom_range(0, 9);
            amt = (r == 0) ? 0 :
                  (r <= 6) ? $urandom_range(1, 400) :
                  (r == 7) ? m_bal :
                  (r == 8) ? (BAL_MAX - m_bal) : $urandom_range(0, BAL_MAX);
            cycle("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), amt);
            lock_cycles = (m_state == LOCK) ? lock_cycles + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
